// File: rtl/usb_rst_pkg.sv
// Shared definitions for the USB host-controller reset sequencer:
// sequencer state encoding and Avalon CSR word addresses.
package usb_rst_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLD    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_COUNT  = 2'd1;
  localparam logic [1:0] ADDR_IRQEN  = 2'd2;
  localparam logic [1:0] ADDR_IRQCLR = 2'd3;

endpackage

// File: rtl/usb_rst_timer.sv
// Loadable up-counter shared by the ASSERT and RECOVER phases.
// at_term flags the cycle on which the count equals the compare value,
// so the caller can leave the phase on that same edge.
module usb_rst_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic [CNT_W-1:0] term_val,
  output logic             at_term
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority over counting so a phase change always restarts cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_term = (cnt == term_val);

endmodule

// File: rtl/usb_rst_sequencer.sv
// Turns the PIO reset-request level into a timed reset for the external USB
// host controller: minimum low width, optional extension while the request
// is held, then a recovery wait before ready. Status, completed-reset count
// and a done interrupt are exposed on a small Avalon-MM slave.
module usb_rst_sequencer
  import usb_rst_pkg::*;
#(
  parameter int ASSERT_CYC  = 5000,
  parameter int RECOVER_CYC = 50000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rst_req,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_rst_n,
  output logic        ready,
  output logic        irq
);

  localparam logic [CNT_W-1:0] ASSERT_TERM  = CNT_W'(ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] RECOVER_TERM = CNT_W'(RECOVER_CYC - 1);

  state_t           state;
  state_t           next_state;
  logic             req_q;
  logic             req_rise;
  logic             tmr_load;
  logic             tmr_inc;
  logic             tmr_term;
  logic [CNT_W-1:0] term_val;
  logic             complete;
  logic             csr_wr;
  logic             irq_clr;
  logic             irq_pend;
  logic             irq_en;
  logic [15:0]      rst_count;
  logic             busy;
  logic             unused_wdata;

  assign req_rise     = rst_req & ~req_q;
  assign csr_wr       = chipselect & ~write_n;
  assign irq_clr      = csr_wr && (address == ADDR_IRQCLR) && writedata[0];
  assign busy         = (state != IDLE);
  assign irq          = irq_pend & irq_en;
  assign unused_wdata = ^writedata[31:1];

  usb_rst_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val ('0),
    .inc      (tmr_inc),
    .term_val (term_val),
    .at_term  (tmr_term)
  );

  // Previous request level, used to find new requests (rising edges only).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= 1'b0;
    end else begin
      req_q <= rst_req;
    end
  end

  // State register; leaving reset starts a full power-on sequence in ASSERT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ASSERT;
    end else begin
      state <= next_state;
    end
  end

  // Next state: requests during ASSERT/HOLD are absorbed, during RECOVER they abort.
  always_comb begin
    next_state = state;
    unique case (state)
      ASSERT:  if (tmr_term) next_state = HOLD;
      HOLD:    if (!rst_req) next_state = RECOVER;
      RECOVER: begin
        if (req_rise) begin
          next_state = ASSERT;
        end else if (tmr_term) begin
          next_state = IDLE;
        end
      end
      IDLE:    if (req_rise) next_state = ASSERT;
      default: next_state = ASSERT;
    endcase
  end

  // Timer control and completion strobe; any state change restarts the count at 0.
  always_comb begin
    tmr_load = (next_state != state);
    tmr_inc  = (state == ASSERT) || (state == RECOVER);
    term_val = (state == RECOVER) ? RECOVER_TERM : ASSERT_TERM;
    complete = (state == RECOVER) && (next_state == IDLE);
  end

  // Registered pins follow the state being entered, giving one-cycle request latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      usb_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      usb_rst_n <= (next_state == RECOVER) || (next_state == IDLE);
      ready     <= (next_state == IDLE);
    end
  end

  // CSR state: interrupt enable, sticky done flag (set beats clear), wrapping count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en    <= 1'b0;
      irq_pend  <= 1'b0;
      rst_count <= 16'd0;
    end else begin
      if (csr_wr && (address == ADDR_IRQEN)) begin
        irq_en <= writedata[0];
      end
      if (complete) begin
        irq_pend  <= 1'b1;
        rst_count <= rst_count + 16'd1;
      end else if (irq_clr) begin
        irq_pend <= 1'b0;
      end
    end
  end

  // Read mux, combinational from the word address.
  always_comb begin
    readdata = 32'd0;
    unique case (address)
      ADDR_STATUS: readdata = {29'd0, irq_pend, busy, ready};
      ADDR_COUNT:  readdata = {16'd0, rst_count};
      ADDR_IRQEN:  readdata = {31'd0, irq_en};
      ADDR_IRQCLR: readdata = 32'd0;
      default:     readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Self-checking bench for usb_rst_sequencer with short timing parameters.
// Expected values come from a constant table, hand-computed sequence lengths
// and a budget-countdown reference model driven alongside the DUT.
module tb_usb_rst_sequencer;

  localparam int ASSERT_CYC  = 4;
  localparam int RECOVER_CYC = 6;

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_COUNT  = 2'd1;
  localparam logic [1:0] A_IRQEN  = 2'd2;
  localparam logic [1:0] A_IRQCLR = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rst_req = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        usb_rst_n;
  logic        ready;
  logic        irq;

  int checks = 0;
  int failures = 0;

  usb_rst_sequencer #(
    .ASSERT_CYC (ASSERT_CYC),
    .RECOVER_CYC(RECOVER_CYC),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rst_req   (rst_req),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .usb_rst_n (usb_rst_n),
    .ready     (ready),
    .irq       (irq)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Reference model: the pin is low while a low-time budget runs out (and while
  // the request is held afterwards), then a recovery budget runs out before ready.
  bit          mLow;
  int          mLowLeft;
  int          mRecLeft;
  bit          mReady;
  bit          mPend;
  bit          mEn;
  bit          mReqQ;
  logic [15:0] mCount;

  function automatic void modelReset();
    mLow     = 1'b1;
    mLowLeft = ASSERT_CYC;
    mRecLeft = 0;
    mReady   = 1'b0;
    mPend    = 1'b0;
    mEn      = 1'b0;
    mReqQ    = 1'b0;
    mCount   = 16'd0;
  endfunction

  function automatic void modelEdge(input logic req, input logic [1:0] addr,
                                    input logic cs, input logic wn, input logic [31:0] wd);
    bit rise;
    bit setPend;
    rise    = req && !mReqQ;
    setPend = 1'b0;
    if (mLow) begin
      if (mLowLeft > 0) begin
        mLowLeft--;
      end else if (!req) begin
        mLow     = 1'b0;
        mRecLeft = RECOVER_CYC;
      end
    end else if (!mReady) begin
      if (rise) begin
        mLow     = 1'b1;
        mLowLeft = ASSERT_CYC;
      end else begin
        mRecLeft--;
        if (mRecLeft == 0) begin
          mReady  = 1'b1;
          setPend = 1'b1;
          mCount  = mCount + 16'd1;
        end
      end
    end else if (rise) begin
      mReady   = 1'b0;
      mLow     = 1'b1;
      mLowLeft = ASSERT_CYC;
    end
    if (cs && !wn && addr == A_IRQEN) mEn = wd[0];
    if (setPend) mPend = 1'b1;
    else if (cs && !wn && addr == A_IRQCLR && wd[0]) mPend = 1'b0;
    mReqQ = req;
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] addr);
    case (addr)
      A_STATUS: return {29'd0, mPend, !mReady, mReady};
      A_COUNT:  return {16'd0, mCount};
      A_IRQEN:  return {31'd0, mEn};
      default:  return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " usb_rst_n"}, {31'd0, usb_rst_n}, {31'd0, !mLow});
    checkOutput({tag, " ready"}, {31'd0, ready}, {31'd0, mReady});
    checkOutput({tag, " irq"}, {31'd0, irq}, {31'd0, mPend & mEn});
    checkOutput({tag, " readdata"}, readdata, modelRead(address));
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then sample 1 ns later.
  task automatic applyStimulus(input logic req, input logic [1:0] addr, input logic cs,
                               input logic wn, input logic [31:0] wd);
    rst_req    = req;
    address    = addr;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    @(posedge clk);
    modelEdge(req, addr, cs, wn, wd);
    #1;
  endtask

  // Hold the request for reqLen cycles, then release and count low / recovering samples.
  task automatic runPulse(input string tag, input int reqLen, output int lowCnt, output int recCnt);
    lowCnt = 0;
    recCnt = 0;
    for (int i = 0; i < reqLen; i++) begin
      applyStimulus(1'b1, A_COUNT, 1'b0, 1'b1, 32'd0);
      checkModel(tag);
      if (!usb_rst_n) lowCnt++;
    end
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, A_COUNT, 1'b0, 1'b1, 32'd0);
      checkModel(tag);
      if (ready) break;
      if (!usb_rst_n) lowCnt++;
      else recCnt++;
    end
    checkOutput({tag, " reached ready"}, {31'd0, ready}, 32'd1);
  endtask

  typedef struct {
    logic        req;
    logic [1:0]  addr;
    logic        expRstN;
    logic        expReady;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[12];

  // Watchdog so a stuck run still ends with a verdict.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int lo;
    int rc;
    int guard;
    bit sawReady;
    logic rq;
    logic [1:0] ra;
    logic wr;

    // Power-on sequence after reset release, one row per rising edge.
    vecs[0]  = '{1'b0, A_STATUS, 1'b0, 1'b0, 32'h2};
    vecs[1]  = '{1'b0, A_COUNT,  1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, A_IRQEN,  1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, A_IRQCLR, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, A_STATUS, 1'b1, 1'b0, 32'h2};
    vecs[5]  = '{1'b0, A_STATUS, 1'b1, 1'b0, 32'h2};
    vecs[6]  = '{1'b0, A_STATUS, 1'b1, 1'b0, 32'h2};
    vecs[7]  = '{1'b0, A_STATUS, 1'b1, 1'b0, 32'h2};
    vecs[8]  = '{1'b0, A_STATUS, 1'b1, 1'b0, 32'h2};
    vecs[9]  = '{1'b0, A_STATUS, 1'b1, 1'b0, 32'h2};
    vecs[10] = '{1'b0, A_STATUS, 1'b1, 1'b1, 32'h5};
    vecs[11] = '{1'b0, A_COUNT,  1'b1, 1'b1, 32'h1};

    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset usb_rst_n", {31'd0, usb_rst_n}, 32'd0);
    checkOutput("reset ready", {31'd0, ready}, 32'd0);
    checkOutput("reset irq", {31'd0, irq}, 32'd0);
    checkOutput("reset status", readdata, 32'h2);
    address = A_COUNT;
    #1;
    checkOutput("reset count", readdata, 32'h0);
    reset = 1'b0;

    $display("[TB] power-on table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].req, vecs[i].addr, 1'b0, 1'b1, 32'd0);
      checkOutput($sformatf("vec%0d usb_rst_n", i), {31'd0, usb_rst_n}, {31'd0, vecs[i].expRstN});
      checkOutput($sformatf("vec%0d ready", i), {31'd0, ready}, {31'd0, vecs[i].expReady});
      checkOutput($sformatf("vec%0d readdata", i), readdata, vecs[i].expRdata);
    end

    $display("[TB] long request extends the pulse");
    runPulse("long", 10, lo, rc);
    checkOutput("long low cycles", lo, 32'd10);
    checkOutput("long recover cycles", rc, RECOVER_CYC);
    checkOutput("long count", readdata, 32'd2);

    $display("[TB] short request gets minimum width");
    runPulse("short", 1, lo, rc);
    checkOutput("short low cycles", lo, ASSERT_CYC + 1);
    checkOutput("short recover cycles", rc, RECOVER_CYC);
    checkOutput("short count", readdata, 32'd3);

    $display("[TB] request during recovery aborts it");
    sawReady = 1'b0;
    applyStimulus(1'b1, A_COUNT, 1'b0, 1'b1, 32'd0);
    checkModel("abort");
    guard = 0;
    while (!usb_rst_n && guard < 50) begin
      applyStimulus(1'b0, A_COUNT, 1'b0, 1'b1, 32'd0);
      checkModel("abort");
      if (ready) sawReady = 1'b1;
      guard++;
    end
    checkOutput("abort reached recover", {31'd0, usb_rst_n}, 32'd1);
    repeat (3) begin
      applyStimulus(1'b0, A_COUNT, 1'b0, 1'b1, 32'd0);
      checkModel("abort");
      if (ready) sawReady = 1'b1;
    end
    applyStimulus(1'b1, A_COUNT, 1'b0, 1'b1, 32'd0);
    checkOutput("abort usb_rst_n low", {31'd0, usb_rst_n}, 32'd0);
    checkOutput("abort count unchanged", readdata, 32'd3);
    runPulse("abort tail", 0, lo, rc);
    checkOutput("abort tail low cycles", lo, ASSERT_CYC);
    checkOutput("abort tail recover cycles", rc, RECOVER_CYC);
    checkOutput("abort ready early", {31'd0, sawReady}, 32'd0);
    checkOutput("abort count", readdata, 32'd4);

    $display("[TB] interrupt enable and clear");
    applyStimulus(1'b0, A_IRQEN, 1'b1, 1'b0, 32'h1);
    checkOutput("irq enabled", {31'd0, irq}, 32'd1);
    applyStimulus(1'b0, A_IRQCLR, 1'b0, 1'b1, 32'd0);
    checkOutput("irqclr reads zero", readdata, 32'd0);
    applyStimulus(1'b0, A_IRQCLR, 1'b1, 1'b0, 32'h1);
    checkOutput("irq cleared", {31'd0, irq}, 32'd0);
    applyStimulus(1'b0, A_STATUS, 1'b0, 1'b1, 32'd0);
    checkOutput("status after clear", readdata, 32'h1);

    $display("[TB] set and clear in the same cycle");
    applyStimulus(1'b1, A_STATUS, 1'b0, 1'b1, 32'd0);
    checkModel("collide");
    guard = 0;
    while (!(!mLow && !mReady && mRecLeft == 1) && guard < 50) begin
      applyStimulus(1'b0, A_STATUS, 1'b0, 1'b1, 32'd0);
      checkModel("collide");
      guard++;
    end
    applyStimulus(1'b0, A_IRQCLR, 1'b1, 1'b0, 32'h1);
    checkOutput("collide irq", {31'd0, irq}, 32'd1);
    applyStimulus(1'b0, A_STATUS, 1'b0, 1'b1, 32'd0);
    checkOutput("collide status", readdata, 32'h5);

    $display("[TB] asynchronous reset during HOLD");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, A_IRQEN, 1'b0, 1'b1, 32'd0);
      checkModel("hold");
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset usb_rst_n", {31'd0, usb_rst_n}, 32'd0);
    checkOutput("midreset ready", {31'd0, ready}, 32'd0);
    checkOutput("midreset irq_en", readdata, 32'd0);
    address = A_COUNT;
    #1;
    checkOutput("midreset count", readdata, 32'd0);
    @(posedge clk);
    #1;
    rst_req = 1'b0;
    reset   = 1'b0;
    modelReset();
    address = A_IRQEN;
    #1;
    checkOutput("postreset irq_en", readdata, 32'd0);
    runPulse("postreset", 0, lo, rc);
    checkOutput("postreset low cycles", lo, ASSERT_CYC);
    checkOutput("postreset recover cycles", rc, RECOVER_CYC);
    checkOutput("postreset count", readdata, 32'd1);

    $display("[TB] randomized traffic against the model");
    rq = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) rq = ~rq;
      ra = 2'($urandom_range(0, 3));
      wr = ($urandom_range(0, 7) == 0);
      applyStimulus(rq, ra, wr, !wr, $urandom);
      checkModel($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
